// File: rtl/uart_rx_fifo_if.sv
// Byte/status bundle between the UART receiver, the CPU data register and the RX FIFO.
// The master drives receiver and CPU strobes; the FIFO (slave) returns data and status.
interface uart_rx_fifo_if #(
   parameter int unsigned AW = 4
);
   logic [7:0]  rx_data;
   logic        rx_stb;
   logic        rd;
   logic        ovr_clr;
   logic [7:0]  rd_data;
   logic        empty;
   logic        full;
   logic [AW:0] level;
   logic        overrun;
   logic        irq_lvl;
   logic        irq_to;

   modport master (
      output rx_data, rx_stb, rd, ovr_clr,
      input  rd_data, empty, full, level, overrun, irq_lvl, irq_to
   );

   modport slave (
      input  rx_data, rx_stb, rd, ovr_clr,
      output rd_data, empty, full, level, overrun, irq_lvl, irq_to
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO behind the UART receiver, with level/overrun
// status, a level-threshold interrupt and an idle-timeout interrupt.
module uart_rx_fifo #(
   parameter int unsigned AW      = 4,
   parameter int unsigned THRESH  = 8,
   parameter logic [15:0] TIMEOUT = 16'd4000
) (
   input  logic           clk,
   input  logic           clr,
   uart_rx_fifo_if.slave  bus
);
   localparam int unsigned DEPTH = 2**AW;

   typedef enum logic [1:0] {IDLE, COUNT, FIRED} to_state_t;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   level;
   logic [AW:0]   lvl_nxt;
   logic          overrun;
   logic          irq_lvl;
   logic          irq_to;
   logic [15:0]   cnt;
   to_state_t     state;

   logic is_empty;
   logic is_full;
   logic do_push;
   logic do_pop;
   logic drop;

   assign is_empty = (level == '0);
   assign is_full  = (level == (AW+1)'(DEPTH));

   // A pop frees the slot in the same cycle, so a full FIFO still accepts a byte with rd.
   assign do_push = bus.rx_stb && (!is_full || bus.rd);
   assign do_pop  = bus.rd && !is_empty;
   assign drop    = bus.rx_stb && is_full && !bus.rd;

   always_comb begin
      lvl_nxt = level;
      unique case ({do_push, do_pop})
         2'b10:   lvl_nxt = level + 1'b1;
         2'b01:   lvl_nxt = level - 1'b1;
         default: lvl_nxt = level;
      endcase
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= bus.rx_data;
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         overrun <= 1'b0;
         irq_lvl <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         level   <= lvl_nxt;
         irq_lvl <= (lvl_nxt >= (AW+1)'(THRESH));
         if (drop)             overrun <= 1'b1;
         else if (bus.ovr_clr) overrun <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state  <= IDLE;
         cnt    <= '0;
         irq_to <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (lvl_nxt != '0) begin
                  state <= COUNT;
                  cnt   <= '0;
               end
            end
            COUNT: begin
               if (lvl_nxt == '0) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (do_push || do_pop) begin
                  cnt <= '0;
               end else if (cnt == TIMEOUT - 16'd1) begin
                  state  <= FIRED;
                  irq_to <= 1'b1;
               end else if (cnt != '1) begin
                  cnt <= cnt + 16'd1;
               end
            end
            FIRED: begin
               // Only draining data acknowledges the timeout; new arrivals keep it raised.
               if (do_pop) begin
                  irq_to <= 1'b0;
                  cnt    <= '0;
                  state  <= (lvl_nxt == '0) ? IDLE : COUNT;
               end
            end
            default: begin
               state  <= IDLE;
               cnt    <= '0;
               irq_to <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rd_data = is_empty ? 8'h00 : mem[rd_ptr];
   assign bus.empty   = is_empty;
   assign bus.full    = is_full;
   assign bus.level   = level;
   assign bus.overrun = overrun;
   assign bus.irq_lvl = irq_lvl;
   assign bus.irq_to  = irq_to;
endmodule
